// File: rtl/ps2_dev_cmd_rx.sv
// rtl/ps2_dev_cmd_rx.sv - device-side PS/2 receiver for host-to-device command frames
// Detects host RTS, generates the PS/2 clock, shifts in data/parity/stop and drives the ack bit.
module ps2_dev_cmd_rx #(
  parameter int PS2_HALF = 750,
  parameter int RTS_MIN  = 2000,
  parameter int GLITCH   = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_active,
  output logic       rx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int CNT_MAX = (RTS_MIN > PS2_HALF) ? RTS_MIN : PS2_HALF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(PS2_HALF - 1);
  localparam logic [CW-1:0] HALF_PREV  = CW'(PS2_HALF - 2);
  localparam logic [CW-1:0] RTS_CNT    = CW'(RTS_MIN);
  localparam logic [CW-1:0] GLITCH_CNT = CW'(GLITCH);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SETUP, S_CLK_LO, S_CLK_HI, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          stop_q, stop_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          busy_q, busy_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_s, dat_s, frame_ok;

  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign frame_ok = stop_q & (^{shreg_q, par_q});

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign rx_busy    = busy_q;
  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_error   = error_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    stop_d   = stop_q;
    dat_oe_d = dat_oe_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!clk_s && !tx_active) begin
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (!clk_s) begin
          if (cnt_q != RTS_CNT) cnt_d = cnt_q + 1'b1;
        end else if (cnt_q >= RTS_CNT && !dat_s) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_CLK_LO;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLK_LO: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_CLK_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLK_HI: begin
        // Early released-high cycles still see our own low through the synchroniser.
        if (!clk_s && cnt_q >= GLITCH_CNT) begin
          state_d  = S_INHIBIT;
          cnt_d    = '0;
          dat_oe_d = 1'b0;
        end else if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (bit_q < 4'd8) shreg_d = {dat_s, shreg_q[7:1]};
          if (bit_q == 4'd8) par_d = dat_s;
          if (bit_q == 4'd9) begin
            stop_d   = dat_s;
            dat_oe_d = dat_s;
          end
          if (bit_q == 4'd10) begin
            state_d = S_DONE;
            valid_d = frame_ok;
            error_d = ~frame_ok;
            if (frame_ok) data_d = shreg_q;
          end else begin
            state_d = S_CLK_LO;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bit_q == 4'd10 && cnt_q == HALF_PREV) dat_oe_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    clk_oe_d = (state_d == S_CLK_LO);
    busy_d   = (state_d == S_SETUP) || (state_d == S_CLK_LO) ||
               (state_d == S_CLK_HI) || (state_d == S_DONE);
    if (state_d == S_IDLE || state_d == S_INHIBIT) dat_oe_d = 1'b0;
  end

endmodule

// File: tb/tb_ps2_dev_cmd_rx.sv
// tb/tb_ps2_dev_cmd_rx.sv - directed bench for ps2_dev_cmd_rx with a timeline model of the frame
module tb_ps2_dev_cmd_rx;

  localparam int H  = 4;
  localparam int FR = 23 * H;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       host_clk_low, host_dat_low;
  logic       tx_active;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       rx_busy, rx_valid, rx_error;
  logic [7:0] rx_data;

  assign ps2_clk_in = ~(ps2_clk_oe | host_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | host_dat_low);

  ps2_dev_cmd_rx #(.PS2_HALF(H), .RTS_MIN(8), .GLITCH(2)) dut (
    .clk_sys    (clk),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_active  (tx_active),
    .rx_busy    (rx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame model: outputs follow from the cycle offset k since SETUP entry.
  logic       m_on = 1'b0;
  int         m_start = 0;
  int         m_cut = 0;
  int         m_zero_at = -1;
  logic [7:0] m_byte = 8'h00;
  logic       m_par = 1'b0;
  logic       m_stop = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         k;
  logic       e_clk, e_dat, e_busy, e_val, e_err, good;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      k = cyc - m_start;
      e_clk = 0; e_dat = 0; e_busy = 0; e_val = 0; e_err = 0;
      if (cyc == m_zero_at) m_data = 8'h00;
      if (m_on && k >= 0 && k < m_cut && k <= FR) begin
        e_busy = 1'b1;
        e_clk  = (k >= H) && (k < FR) && (((k - H) % (2 * H)) < H);
        e_dat  = m_stop && (k >= 21 * H) && (k <= FR - 2);
        if (k == FR) begin
          good  = m_stop && (^{m_byte, m_par});
          e_val = good;
          e_err = !good;
          if (good) m_data = m_byte;
        end
      end
      chk("clk_oe",   ps2_clk_oe, e_clk);
      chk("dat_oe",   ps2_dat_oe, e_dat);
      chk("rx_busy",  rx_busy,    e_busy);
      chk("rx_valid", rx_valid,   e_val);
      chk("rx_error", rx_error,   e_err);
      chk("rx_data",  rx_data,    m_data);
    end
  end

  // Observation counters for the hand-computed checks.
  int   mon_pulses, mon_ack, mon_val, mon_err, mon_busy_rise, busy_rise_cyc, val_cyc;
  logic prev_clk_oe = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (ps2_clk_oe === 1'b1 && prev_clk_oe === 1'b0) mon_pulses++;
    if (ps2_dat_oe === 1'b1) mon_ack++;
    if (rx_valid === 1'b1) begin mon_val++; val_cyc = cyc; end
    if (rx_error === 1'b1) mon_err++;
    if (rx_busy === 1'b1 && prev_busy === 1'b0) begin mon_busy_rise++; busy_rise_cyc = cyc; end
    prev_clk_oe = ps2_clk_oe;
    prev_busy   = rx_busy;
  end

  task automatic mon_clear();
    mon_pulses = 0; mon_ack = 0; mon_val = 0; mon_err = 0; mon_busy_rise = 0;
    busy_rise_cyc = 0; val_cyc = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input int abort_k, input int reset_k, input logic tx_mid);
    logic [10:0] bits;
    int t;
    bits = {1'b1, s, p, b};
    host_clk_low = 1'b1;
    step(6);
    host_dat_low = 1'b1;
    step(6);
    m_byte = b; m_par = p; m_stop = s;
    m_cut = FR + 1;
    if (abort_k >= 0) m_cut = abort_k + 3;
    if (reset_k >= 0) m_cut = reset_k + 1;
    host_clk_low = 1'b0;
    m_start = cyc + 3;
    m_on = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      t = H + 2 * H * n + 1;
      if (abort_k >= 0 && t >= abort_k) break;
      if (reset_k >= 0 && t >= reset_k) break;
      wait_until(m_start + t);
      host_dat_low = ~bits[n];
      if (tx_mid && n == 3) tx_active = 1'b1;
    end
    if (abort_k >= 0) begin
      wait_until(m_start + abort_k);
      host_clk_low = 1'b1;
      host_dat_low = 1'b1;
      step(14);
    end else if (reset_k >= 0) begin
      wait_until(m_start + reset_k);
      reset_n = 1'b0;
      host_clk_low = 1'b0;
      host_dat_low = 1'b0;
      m_zero_at = cyc + 1;
      step(2);
      reset_n = 1'b1;
      step(5);
    end else begin
      wait_until(m_start + FR + 6);
    end
    tx_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    host_clk_low = 1'b0;
    host_dat_low = 1'b0;
    tx_active = 1'b0;
    mon_clear();
    step(3);
    reset_n = 1'b1;
    step(5);
    chk("reset_clk_oe", ps2_clk_oe, 1'b0);
    chk("reset_dat_oe", ps2_dat_oe, 1'b0);
    chk("reset_busy",   rx_busy,    1'b0);
    chk("reset_data",   rx_data,    8'h00);

    // LED command 0xED, odd parity bit 1, stop 1
    mon_clear();
    send_frame(8'hED, 1'b1, 1'b1, -1, -1, 1'b0);
    chk("led_pulses",  mon_pulses, 11);
    chk("led_ack",     mon_ack, 7);
    chk("led_valid",   mon_val, 1);
    chk("led_error",   mon_err, 0);
    chk("led_latency", val_cyc - busy_rise_cyc, 92);
    chk("led_data",    rx_data, 8'hED);

    // 0xF4 with parity 1 is a parity error
    mon_clear();
    send_frame(8'hF4, 1'b1, 1'b1, -1, -1, 1'b0);
    chk("par_ack",   mon_ack, 7);
    chk("par_valid", mon_val, 0);
    chk("par_error", mon_err, 1);
    chk("par_data",  rx_data, 8'hED);

    // Short inhibit: 5 cycles of clock low
    mon_clear();
    host_clk_low = 1'b1;
    host_dat_low = 1'b1;
    step(5);
    host_clk_low = 1'b0;
    step(4);
    host_dat_low = 1'b0;
    step(6);
    chk("short_pulses", mon_pulses, 0);
    chk("short_busy",   mon_busy_rise, 0);

    // Host abort in CLK_HI(4), then 0xFF with tx_active raised mid-frame
    mon_clear();
    send_frame(8'h5A, 1'b1, 1'b1, 40, -1, 1'b0);
    chk("abort_pulses", mon_pulses, 5);
    chk("abort_valid",  mon_val, 0);
    chk("abort_error",  mon_err, 0);
    chk("abort_dat_oe", ps2_dat_oe, 1'b0);
    mon_clear();
    send_frame(8'hFF, 1'b1, 1'b1, -1, -1, 1'b1);
    chk("ff_pulses", mon_pulses, 11);
    chk("ff_valid",  mon_val, 1);
    chk("ff_data",   rx_data, 8'hFF);

    // Stop bit 0: no ack, clock 10 still generated
    mon_clear();
    send_frame(8'h12, 1'b1, 1'b0, -1, -1, 1'b0);
    chk("stop_pulses", mon_pulses, 11);
    chk("stop_ack",    mon_ack, 0);
    chk("stop_error",  mon_err, 1);
    chk("stop_data",   rx_data, 8'hFF);

    // Reset during CLK_LO(6)
    mon_clear();
    send_frame(8'h3C, 1'b1, 1'b1, -1, 53, 1'b0);
    chk("rst_pulses", mon_pulses, 7);
    chk("rst_valid",  mon_val, 0);
    chk("rst_error",  mon_err, 0);
    chk("rst_data",   rx_data, 8'h00);

    // RTS while the transmitter is active is ignored
    mon_clear();
    tx_active = 1'b1;
    host_clk_low = 1'b1;
    step(6);
    host_dat_low = 1'b1;
    step(6);
    host_clk_low = 1'b0;
    step(4);
    tx_active = 1'b0;
    step(2);
    host_dat_low = 1'b0;
    step(6);
    chk("txa_pulses", mon_pulses, 0);
    chk("txa_busy",   mon_busy_rise, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
